prog_clock_divider: RTL and testbench

Runtime-programmable clock divider and tick generator. Successor to the fixed-ratio 1 kHz divider. Derives a square-wave `clk_out` plus single-cycle strobes from the system clock, for display scan, debounce and timebase logic. The divisor is loaded at run time through a load handshake and applied glitch-free at the next period boundary. Enable, phase-clear and synchronous active-low reset are supported.

---
 rtl/prog_clock_divider.sv | 96 +++++++++
 tb/tb_prog_clock_divider.sv | 133 +++++++++++++
 2 files changed

// File: rtl/prog_clock_divider.sv
// rtl/prog_clock_divider.sv - runtime-programmable clock divider and tick generator
// New divisors wait in pending_div_q and take effect only at a period boundary.
module prog_clock_divider #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEFAULT_DIV = 50000
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             sync_clr,
  input  logic [WIDTH-1:0] div_value,
  input  logic             div_load,
  output logic             div_busy,
  output logic             clk_out,
  output logic             tick,
  output logic             period_done
);

  localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);
  localparam logic [WIDTH-1:0] DEF_DIV =
    (DEFAULT_DIV < 2) ? MIN_DIV : WIDTH'(DEFAULT_DIV);

  function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] v);
    return (v < MIN_DIV) ? MIN_DIV : v;
  endfunction

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] active_div_q, active_div_d;
  logic [WIDTH-1:0] pending_div_q, pending_div_d;
  logic             busy_q, busy_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             period_done_q, period_done_d;

  logic             wrap;
  logic             boundary;
  logic [WIDTH-1:0] low_len_d;

  assign wrap     = enable && (cnt_q == active_div_q - WIDTH'(1));
  assign boundary = sync_clr || wrap;

  always_comb begin
    cnt_d         = cnt_q;
    active_div_d  = active_div_q;
    pending_div_d = pending_div_q;
    busy_d        = busy_q;

    if (boundary) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + WIDTH'(1);
    end

    if (boundary && busy_q) begin
      active_div_d = pending_div_q;
      busy_d       = 1'b0;
    end

    // A load on the boundary cycle itself re-arms busy for the next boundary.
    if (div_load) begin
      pending_div_d = clamp_div(div_value);
      busy_d        = 1'b1;
    end
  end

  assign low_len_d     = active_div_d >> 1;
  assign clk_out_d     = (cnt_d >= low_len_d);
  assign tick_d        = enable && (cnt_d == low_len_d);
  assign period_done_d = wrap && !sync_clr;

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      cnt_q         <= '0;
      active_div_q  <= DEF_DIV;
      pending_div_q <= '0;
      busy_q        <= 1'b0;
      clk_out_q     <= 1'b0;
      tick_q        <= 1'b0;
      period_done_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      active_div_q  <= active_div_d;
      pending_div_q <= pending_div_d;
      busy_q        <= busy_d;
      clk_out_q     <= clk_out_d;
      tick_q        <= tick_d;
      period_done_q <= period_done_d;
    end
  end

  assign div_busy    = busy_q;
  assign clk_out     = clk_out_q;
  assign tick        = tick_q;
  assign period_done = period_done_q;

endmodule

// File: tb/tb_prog_clock_divider.sv
// tb/tb_prog_clock_divider.sv - scoreboard bench for prog_clock_divider
// Stimulus queues the expected {clk_out, tick, period_done, div_busy}; the monitor checks it.
module tb_prog_clock_divider;

  logic        clk_in = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b1;
  logic        sync_clr = 1'b0;
  logic [15:0] div_value = '0;
  logic        div_load = 1'b0;
  logic        div_busy, clk_out, tick, period_done;

  logic [3:0]  exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_step = 0;

  prog_clock_divider #(.WIDTH(16), .DEFAULT_DIV(50000)) dut (
    .clk_in      (clk_in),
    .reset_n     (reset_n),
    .enable      (enable),
    .sync_clr    (sync_clr),
    .div_value   (div_value),
    .div_load    (div_load),
    .div_busy    (div_busy),
    .clk_out     (clk_out),
    .tick        (tick),
    .period_done (period_done)
  );

  always #5 clk_in = ~clk_in;

  // Expected outputs while observing position c of an enabled period of length div.
  function automatic logic [3:0] ex(input int c, input int div, input logic pd, input logic b);
    return {(c >= div / 2), (c == div / 2), pd, b};
  endfunction

  task automatic drive(input logic rn, input logic en, input logic clr, input logic ld,
                       input logic [15:0] v, input logic [3:0] e);
    @(negedge clk_in);
    reset_n   = rn;
    enable    = en;
    sync_clr  = clr;
    div_load  = ld;
    div_value = v;
    exp_q.push_back(e);
  endtask

  task automatic run_period(input int div, input int n);
    for (int p = 0; p < n; p++) begin
      for (int c = 1; c < div; c++) drive(1, 1, 0, 0, 0, ex(c, div, 0, 0));
      drive(1, 1, 0, 0, 0, ex(0, div, 1, 0));
    end
  endtask

  always @(posedge clk_in) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [3:0] e;
      logic [3:0] got;
      e   = exp_q.pop_front();
      got = {clk_out, tick, period_done, div_busy};
      n_checks++;
      n_step++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL step%0d clk/tick/pd/busy got %b want %b", n_step, got, e);
      end
    end
  end

  initial begin
    // reset, then default ratio with a load of 5 pending for the whole first period
    repeat (3) drive(0, 1, 0, 0, 0, 4'b0000);
    drive(1, 1, 0, 0, 0, ex(1, 50000, 0, 0));
    drive(1, 1, 0, 1, 16'd5, ex(2, 50000, 0, 1));
    for (int c = 3; c < 50000; c++) drive(1, 1, 0, 0, 0, ex(c, 50000, 0, 1));
    drive(1, 1, 0, 0, 0, ex(0, 5, 1, 0));
    run_period(5, 2);

    // clamp and overwrite: 0, 1, 7 back to back, 7 wins
    drive(1, 1, 0, 1, 16'd0, ex(1, 5, 0, 1));
    drive(1, 1, 0, 1, 16'd1, ex(2, 5, 0, 1));
    drive(1, 1, 0, 1, 16'd7, ex(3, 5, 0, 1));
    drive(1, 1, 0, 0, 0, ex(4, 5, 0, 1));
    drive(1, 1, 0, 0, 0, ex(0, 7, 1, 0));

    // load of 1 clamps to 2
    drive(1, 1, 0, 1, 16'd1, ex(1, 7, 0, 1));
    for (int c = 2; c < 7; c++) drive(1, 1, 0, 0, 0, ex(c, 7, 0, 1));
    drive(1, 1, 0, 0, 0, ex(0, 2, 1, 0));
    run_period(2, 3);

    // enable gating at div=6, frozen in the high phase
    drive(1, 1, 0, 1, 16'd6, ex(1, 2, 0, 1));
    drive(1, 1, 0, 0, 0, ex(0, 6, 1, 0));
    for (int c = 1; c < 5; c++) drive(1, 1, 0, 0, 0, ex(c, 6, 0, 0));
    repeat (10) drive(1, 0, 0, 0, 0, 4'b1000);
    drive(1, 1, 0, 0, 0, ex(5, 6, 0, 0));
    drive(1, 1, 0, 0, 0, ex(0, 6, 1, 0));

    // div=8, load 4, phase clear at cnt=5 applies 4 without period_done
    drive(1, 1, 0, 1, 16'd8, ex(1, 6, 0, 1));
    for (int c = 2; c < 6; c++) drive(1, 1, 0, 0, 0, ex(c, 6, 0, 1));
    drive(1, 1, 0, 0, 0, ex(0, 8, 1, 0));
    drive(1, 1, 0, 1, 16'd4, ex(1, 8, 0, 1));
    for (int c = 2; c < 6; c++) drive(1, 1, 0, 0, 0, ex(c, 8, 0, 1));
    drive(1, 1, 1, 0, 0, 4'b0000);
    run_period(4, 2);

    // reset while 10 is pending discards it
    drive(1, 1, 0, 1, 16'd10, ex(1, 4, 0, 1));
    drive(1, 1, 0, 0, 0, ex(2, 4, 0, 1));
    repeat (2) drive(0, 1, 0, 0, 0, 4'b0000);
    for (int c = 1; c <= 300; c++) drive(1, 1, 0, 0, 0, ex(c, 50000, 0, 0));

    // phase clear acts while disabled
    drive(1, 0, 1, 0, 0, 4'b0000);
    drive(1, 1, 0, 0, 0, ex(1, 50000, 0, 0));
    drive(1, 1, 0, 0, 0, ex(2, 50000, 0, 0));

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk_in);
    #3;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain %0d entries left want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
